// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave front-end.
// Optional feature macro: SPI_FRAME_ERR_EN (adds frame_err abort flag).
package spi_pkg;

  localparam int SPI_WORD_W = 10;
  localparam int SPI_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: SPI pins plus the RAM-side word/read-data handshake.
// frame_err exists only when SPI_FRAME_ERR_EN is defined.
interface spi_slave_ctrl_if #(
  parameter int WORD_W = 10,
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic [WORD_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic              frame_err;
`endif

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_FRAME_ERR_EN
    output frame_err,
`endif
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
`ifdef SPI_FRAME_ERR_EN
    input  frame_err,
`endif
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_ctrl_miso_ser.sv
// spi_miso_ser: parallel-load MSB-first shifter driving MISO.
// The load edge already drives the MSB; MISO returns to 0 once drained.
module spi_miso_ser
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              abort,
  input  logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              MISO
);
  logic [DATA_W-1:0] sh_reg;
  logic [3:0]        cnt_reg;
  logic              miso_reg;

  // Shift one bit per cycle after a load; abort clears immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg   <= '0;
      cnt_reg  <= 4'd0;
      miso_reg <= 1'b0;
    end else if (abort) begin
      sh_reg   <= '0;
      cnt_reg  <= 4'd0;
      miso_reg <= 1'b0;
    end else if (load) begin
      miso_reg <= din[DATA_W-1];
      sh_reg   <= {din[DATA_W-2:0], 1'b0};
      cnt_reg  <= 4'(DATA_W - 1);
    end else if (cnt_reg != 4'd0) begin
      miso_reg <= sh_reg[DATA_W-1];
      sh_reg   <= {sh_reg[DATA_W-2:0], 1'b0};
      cnt_reg  <= cnt_reg - 4'd1;
    end else begin
      miso_reg <= 1'b0;
    end
  end

  assign busy = (cnt_reg != 4'd0);
  assign MISO = miso_reg;
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave front-end feeding a single-port RAM.
// Deserialises 10-bit command/data words, returns read data on MISO.
// Optional: define SPI_FRAME_ERR_EN to get the frame_err abort pulse.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int WORD_W = SPI_WORD_W,
  parameter int DATA_W = SPI_DATA_W
) (
  input logic             clk,
  input logic             rst_n,
  spi_slave_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'(ST_IDLE);
  localparam logic [2:0] CHK_CMD   = 3'(ST_CHK_CMD);
  localparam logic [2:0] WRITE     = 3'(ST_WRITE);
  localparam logic [2:0] READ_ADD  = 3'(ST_READ_ADD);
  localparam logic [2:0] READ_DATA = 3'(ST_READ_DATA);
  localparam logic [3:0] WORD_LAST = 4'(WORD_W);

  logic [2:0]        state_reg, state_next;
  logic [3:0]        bit_cnt_reg;
  logic [WORD_W-2:0] shift_reg;
  logic [WORD_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              rd_addr_seen_reg;
  logic              tx_pending_reg;
  logic              in_word_state, word_done, last_bit;
  logic              ser_load, ser_busy;

  assign in_word_state = (state_reg == WRITE) || (state_reg == READ_ADD) ||
                         (state_reg == READ_DATA);
  assign word_done     = (bit_cnt_reg == WORD_LAST);
  assign last_bit      = in_word_state && (bit_cnt_reg == WORD_LAST - 4'd1);
  // Never reload over a byte still in flight
  assign ser_load      = tx_pending_reg && bus.tx_valid && !bus.SS_n && !ser_busy;

  // Next-state decode; deselect always wins
  always_comb begin
    state_next = state_reg;
    if (bus.SS_n) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = CHK_CMD;
        CHK_CMD: begin
          if (!bus.MOSI)            state_next = WRITE;
          else if (rd_addr_seen_reg) state_next = READ_DATA;
          else                       state_next = READ_ADD;
        end
        default: state_next = in_word_state ? state_reg : IDLE;
      endcase
    end
  end

  // State, bit shifting, word hand-off and read-data wait tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      bit_cnt_reg      <= 4'd0;
      shift_reg        <= '0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
      rd_addr_seen_reg <= 1'b0;
      tx_pending_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rx_valid_reg <= 1'b0;
      if (bus.SS_n || state_reg == IDLE) begin
        bit_cnt_reg    <= 4'd0;
        tx_pending_reg <= 1'b0;
      end else if (state_reg == CHK_CMD) begin
        shift_reg   <= {shift_reg[WORD_W-3:0], bus.MOSI};
        bit_cnt_reg <= 4'd1;
      end else if (in_word_state && !word_done) begin
        shift_reg   <= {shift_reg[WORD_W-3:0], bus.MOSI};
        bit_cnt_reg <= bit_cnt_reg + 4'd1;
        if (last_bit) begin
          rx_data_reg  <= {shift_reg, bus.MOSI};
          rx_valid_reg <= 1'b1;
          if (state_reg == READ_ADD) rd_addr_seen_reg <= 1'b1;
          if (state_reg == READ_DATA) begin
            rd_addr_seen_reg <= 1'b0;
            tx_pending_reg   <= 1'b1;
          end
        end
      end else if (ser_load) begin
        tx_pending_reg <= 1'b0;
      end
    end
  end

  spi_miso_ser #(.DATA_W(DATA_W)) u_miso_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .abort (bus.SS_n),
    .din   (bus.tx_data),
    .busy  (ser_busy),
    .MISO  (bus.MISO)
  );

  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_reg;
  logic incomplete;

  assign incomplete = (state_reg == CHK_CMD) || (in_word_state && !word_done) ||
                      tx_pending_reg || ser_busy;

  // Flag a deselect that cuts a word or a MISO byte short
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_reg <= 1'b0;
    else        frame_err_reg <= bus.SS_n && incomplete;
  end

  assign bus.frame_err = frame_err_reg;
`endif
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed frames with hand-computed expectations.
// Define SPI_FRAME_ERR_EN to also check the frame_err pulses.
module tb_spi_slave_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_ctrl_if #(.WORD_W(10), .DATA_W(8)) bus();
  spi_slave_ctrl #(.WORD_W(10), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int rv_seen = 0;
  int fe_seen = 0;
  logic       rv_log [0:10];
  logic       ms_log [0:10];
  logic [9:0] rxd_k0;

  // Count rx_valid pulses seen mid-cycle
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) rv_seen++;
  end

`ifdef SPI_FRAME_ERR_EN
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_seen++;
  end
`endif

  // RAM model: answers a read-data word with 8'h3C one cycle later
  always @(posedge clk) begin
    bus.tx_valid <= (bus.rx_valid === 1'b1) && (bus.rx_data[9:8] == 2'b11);
    bus.tx_data  <= 8'h3C;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame();
    @(negedge clk);
    bus.SS_n = 1'b0;
    bus.MOSI = 1'b0;
  endtask

  task automatic send_bits(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.MOSI = w[9-i];
    end
  endtask

  task automatic log_cycles();
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      rv_log[k] = bus.rx_valid;
      ms_log[k] = bus.MISO;
      if (k == 0) rxd_k0 = bus.rx_data;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic full_frame(input string tag, input logic [9:0] w, input logic [7:0] exp_byte);
    int rv0;
    int fe0;
    logic [7:0] byte_got;
    rv0 = rv_seen;
    fe0 = fe_seen;
    start_frame();
    send_bits(w, 10);
    log_cycles();
    byte_got = {ms_log[2], ms_log[3], ms_log[4], ms_log[5],
                ms_log[6], ms_log[7], ms_log[8], ms_log[9]};
    chk({tag, "_rv_at_n11"}, 32'(rv_log[0]), 32'd1);
    chk({tag, "_rv_one_cycle"}, 32'(rv_log[1]), 32'd0);
    chk({tag, "_rx_data"}, 32'(rxd_k0), 32'(w));
    end_frame();
    chk({tag, "_rv_pulses"}, 32'(rv_seen - rv0), 32'd1);
    chk({tag, "_miso_byte"}, 32'(byte_got), 32'(exp_byte));
    chk({tag, "_miso_tail"}, 32'(ms_log[10]), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk({tag, "_no_frame_err"}, 32'(fe_seen - fe0), 32'd0);
`endif
    $display("frame %s word=%03h rx_data=%03h miso=%02h", tag, w, rxd_k0, byte_got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rv0;
    int fe0;
    rst_n    = 1'b0;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;

    // Reset held while SS_n toggles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.SS_n = ~bus.SS_n;
      bus.MOSI = 1'b1;
      #1;
      chk("rst_miso", 32'(bus.MISO), 32'd0);
      chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    end
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(negedge clk);
    $display("reset released");

    full_frame("wr_addr", 10'h0A5, 8'h00);
    full_frame("wr_data", 10'h13C, 8'h00);
    full_frame("rd_addr", 10'h2A5, 8'h00);
    full_frame("rd_data", 10'h300, 8'h3C);
    // rd_addr_seen cleared: this one is treated as a read-address
    full_frame("rd_no_addr", 10'h300, 8'h00);
    full_frame("rd_data2", 10'h300, 8'h3C);

    // Abort after 5 bits of a write frame
    rv0 = rv_seen;
    fe0 = fe_seen;
    start_frame();
    send_bits(10'h0A5, 5);
    end_frame();
    chk("abort_no_rv", 32'(rv_seen - rv0), 32'd0);
`ifdef SPI_FRAME_ERR_EN
    chk("abort_frame_err", 32'(fe_seen - fe0), 32'd1);
`endif
    $display("frame abort bits=5 rv_pulses=%0d", rv_seen - rv0);
    full_frame("after_abort", 10'h055, 8'h00);

    // Async reset in the middle of a MISO byte
    full_frame("rd_addr_b", 10'h201, 8'h00);
    start_frame();
    send_bits(10'h300, 10);
    for (int k = 0; k <= 4; k++) @(negedge clk);
    chk("mid_byte_miso", 32'(bus.MISO), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_miso", 32'(bus.MISO), 32'd0);
    chk("async_rst_rx_data", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    @(negedge clk);
    $display("frame async_reset miso=%0b", bus.MISO);
    full_frame("post_rst_wr", 10'h0F0, 8'h00);
    // Reset cleared rd_addr_seen, so this is a read-address
    full_frame("post_rst_rd", 10'h355, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
